up_dn_counter_gen: RTL and testbench

Parametrised successor to the team's 5-bit up/down counter.
- Adds async reset, count enable, runtime step size, programmable lower/upper bounds, and a saturate-or-wrap mode.
- Adds registered overflow/underflow pulses.
- Drop-in for timer/index generation in datapath control.
- With WIDTH=5, Min_Val=0, Max_Val=31, Step=1, Wrap_En=0, En=1, it matches the legacy Load/Up/Down/High/Low behaviour cycle for cycle, except for reset.

---
 rtl/up_dn_counter_gen.sv | 103 ++++++++++
 tb/tb_up_dn_counter_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/up_dn_counter_gen.sv
// Bounded up/down counter with load, enable, runtime step, saturate-or-wrap mode
// and registered overflow/underflow pulses.
module up_dn_counter_gen #(
  parameter int unsigned      WIDTH   = 5,
  parameter int unsigned      STEP_W  = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  IN,
  input  logic              Load,
  input  logic              Up,
  input  logic              Down,
  input  logic              En,
  input  logic [STEP_W-1:0] Step,
  input  logic              Wrap_En,
  input  logic [WIDTH-1:0]  Min_Val,
  input  logic [WIDTH-1:0]  Max_Val,
  output logic [WIDTH-1:0]  Counter,
  output logic              High,
  output logic              Low,
  output logic              Ovf,
  output logic              Unf,
  output logic              Cfg_Err
);

  // Wide enough that sums and differences of counter, step and range never wrap.
  localparam int unsigned AW = WIDTH + STEP_W + 1;

  logic [AW-1:0]    cnt_x;
  logic [AW-1:0]    min_x;
  logic [AW-1:0]    max_x;
  logic [AW-1:0]    step_x;
  logic [AW-1:0]    in_x;
  logic [AW-1:0]    range_x;
  logic             active;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;

  assign cnt_x   = AW'(Counter);
  assign min_x   = AW'(Min_Val);
  assign max_x   = AW'(Max_Val);
  assign step_x  = AW'(Step);
  assign in_x    = AW'(IN);
  assign range_x = max_x - min_x + AW'(1);

  assign Cfg_Err = (Min_Val > Max_Val);
  assign High    = (Counter == Max_Val);
  assign Low     = (Counter == Min_Val);
  assign active  = En && (Up || Down) && (Step != '0);

  // Next count and pulse selection in priority order.
  always_comb begin
    cnt_nxt = Counter;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    if (!Cfg_Err) begin
      if (Load) begin
        if (in_x < min_x)      cnt_nxt = Min_Val;
        else if (in_x > max_x) cnt_nxt = Max_Val;
        else                   cnt_nxt = IN;
      end else if (active) begin
        if (cnt_x < min_x) begin
          cnt_nxt = Min_Val;
        end else if (cnt_x > max_x) begin
          cnt_nxt = Max_Val;
        end else if (Down) begin
          if (step_x <= cnt_x - min_x) begin
            cnt_nxt = WIDTH'(cnt_x - step_x);
          end else begin
            unf_nxt = 1'b1;
            if (!Wrap_En)              cnt_nxt = Min_Val;
            else if (step_x > range_x) cnt_nxt = Max_Val;
            else                       cnt_nxt = WIDTH'(cnt_x + range_x - step_x);
          end
        end else begin
          if (cnt_x + step_x <= max_x) begin
            cnt_nxt = WIDTH'(cnt_x + step_x);
          end else begin
            ovf_nxt = 1'b1;
            if (!Wrap_En)              cnt_nxt = Max_Val;
            else if (step_x > range_x) cnt_nxt = Min_Val;
            else                       cnt_nxt = WIDTH'(cnt_x + step_x - range_x);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Counter <= RST_VAL;
      Ovf     <= 1'b0;
      Unf     <= 1'b0;
    end else begin
      Counter <= cnt_nxt;
      Ovf     <= ovf_nxt;
      Unf     <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_up_dn_counter_gen.sv
// Directed and random stimulus for up_dn_counter_gen, checked against an
// integer-arithmetic reference of the counting rules.
module tb_up_dn_counter_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] in_v;
  logic       load, up, down, en, wrap;
  logic [2:0] step_v;
  logic [4:0] min_v, max_v;
  logic [4:0] counter;
  logic       high, low, ovf, unf, cfg_err;

  int total = 0;
  int bad   = 0;
  int m_cnt;
  int m_ovf;
  int m_unf;

  always #5 clk = ~clk;

  up_dn_counter_gen #(.WIDTH(5), .STEP_W(3), .RST_VAL(5'd3)) dut (
    .clk(clk), .rst(rst), .IN(in_v), .Load(load), .Up(up), .Down(down),
    .En(en), .Step(step_v), .Wrap_En(wrap), .Min_Val(min_v), .Max_Val(max_v),
    .Counter(counter), .High(high), .Low(low), .Ovf(ovf), .Unf(unf),
    .Cfg_Err(cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int mn, mx;
    mn = int'(min_v);
    mx = int'(max_v);
    chk({tag, ".cnt"}, 32'(counter), 32'(m_cnt));
    chk({tag, ".ovf"}, 32'(ovf),     32'(m_ovf));
    chk({tag, ".unf"}, 32'(unf),     32'(m_unf));
    chk({tag, ".high"}, 32'(high),   32'(m_cnt == mx));
    chk({tag, ".low"},  32'(low),    32'(m_cnt == mn));
    chk({tag, ".cfg"},  32'(cfg_err), 32'(mn > mx));
  endtask

  // One clock: predict from current inputs, step, then compare.
  task automatic cyc(input string tag);
    int mn, mx, st, c, r, t, nc, o, u, iv;
    mn = int'(min_v); mx = int'(max_v); st = int'(step_v); iv = int'(in_v);
    c = m_cnt; r = mx - mn + 1; nc = c; o = 0; u = 0;
    if (mn > mx) begin
      nc = c;
    end else if (load) begin
      nc = (iv < mn) ? mn : (iv > mx) ? mx : iv;
    end else if (en && (up || down) && st != 0) begin
      if (c < mn) nc = mn;
      else if (c > mx) nc = mx;
      else if (down) begin
        t = c - st;
        if (t >= mn) nc = t;
        else begin u = 1; nc = !wrap ? mn : (st > r ? mx : t + r); end
      end else begin
        t = c + st;
        if (t <= mx) nc = t;
        else begin o = 1; nc = !wrap ? mx : (st > r ? mn : t - r); end
      end
    end
    @(posedge clk);
    #1;
    m_cnt = nc; m_ovf = o; m_unf = u;
    check_all(tag);
  endtask

  task automatic idle();
    load = 0; up = 0; down = 0; en = 1; in_v = '0;
  endtask

  initial begin
    rst = 1; idle(); step_v = 3'd1; wrap = 0; min_v = 5'd0; max_v = 5'd31;
    m_cnt = 3; m_ovf = 0; m_unf = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 0;

    // Legacy-equivalent configuration
    load = 1; in_v = 5'd30; cyc("t1.load");
    load = 0; up = 1; cyc("t1.up1"); cyc("t1.up2"); cyc("t1.up3");
    chk("t1.sat_ovf", 32'(ovf), 32'd1);
    up = 0; down = 1; cyc("t1.dn");
    up = 1; cyc("t1.both");
    chk("t1.both_val", 32'(counter), 32'd29);

    // Wrap with step 5 in [4,20]
    idle(); min_v = 5'd4; max_v = 5'd20; step_v = 3'd5; wrap = 1;
    load = 1; in_v = 5'd18; cyc("t2.load");
    load = 0; up = 1; cyc("t2.up");
    chk("t2.wrap_val", 32'(counter), 32'd6);
    up = 0; down = 1; cyc("t2.dn1"); cyc("t2.dn2");

    // Load clamp, then inverted bounds
    idle(); load = 1; in_v = 5'd25; cyc("t3.clamp");
    chk("t3.clamp_val", 32'(counter), 32'd20);
    min_v = 5'd10; max_v = 5'd5; in_v = 5'd7; cyc("t3.cfg_load");
    load = 0; up = 1; cyc("t3.cfg_up");

    // Runtime bound shrink
    idle(); min_v = 5'd0; max_v = 5'd31; step_v = 3'd1; wrap = 0;
    load = 1; in_v = 5'd15; cyc("t4.load");
    load = 0; max_v = 5'd10; up = 1; cyc("t4.shrink");
    chk("t4.shrink_val", 32'(counter), 32'd10);
    en = 0; cyc("t4.en0");

    // Step 0 and step larger than the range
    idle(); min_v = 5'd0; max_v = 5'd3; wrap = 1;
    load = 1; in_v = 5'd2; cyc("t6.load");
    load = 0; up = 1; step_v = 3'd0; cyc("t6.step0");
    step_v = 3'd7; cyc("t6.step7");
    chk("t6.step7_val", 32'(counter), 32'd0);

    // Async reset while an overflow pulse is showing
    idle(); min_v = 5'd0; max_v = 5'd31; step_v = 3'd1; wrap = 0;
    load = 1; in_v = 5'd31; cyc("t5.load");
    load = 0; up = 1; cyc("t5.sat");
    #2 rst = 1;
    #1;
    m_cnt = 3; m_ovf = 0; m_unf = 0;
    check_all("t5.async");
    rst = 0;
    cyc("t5.resume");
    chk("t5.resume_val", 32'(counter), 32'd4);

    // Randomised operation with mostly-valid bounds
    for (int i = 0; i < 400; i++) begin
      min_v  = 5'($urandom_range(0, 20));
      max_v  = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31))
                                            : 5'($urandom_range(int'(min_v), 31));
      step_v = 3'($urandom);
      wrap   = 1'($urandom);
      en     = ($urandom_range(0, 7) != 0);
      load   = ($urandom_range(0, 9) == 0);
      up     = 1'($urandom);
      down   = 1'($urandom);
      in_v   = 5'($urandom);
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
